snes_ppu_reg_snoop: RTL



---
 rtl/snes_ppu_reg_snoop_pkg.sv | 58 +++++
 rtl/snes_ppu_reg_snoop_if.sv | 10 +
 rtl/snes_ppu_reg_snoop_bbus_write_detect.sv | 70 +++++++
 rtl/snes_ppu_reg_snoop.sv | 99 +++++++++
 4 files changed

// File: rtl/snes_ppu_reg_snoop_pkg.sv
// Shared types for the SNES PPU register snooper: B-bus addresses,
// display-state bundle, synchroniser sample and register-write helpers.
package snes_ppu_pkg;

    localparam logic [7:0] PPU_ADDR_INIDISP = 8'h00;
    localparam logic [7:0] PPU_ADDR_BGMODE  = 8'h05;
    localparam logic [7:0] PPU_ADDR_M7SEL   = 8'h1A;
    localparam logic [7:0] PPU_ADDR_SETINI  = 8'h33;

    typedef struct packed {
        logic [3:0] brightness;
        logic       force_blank;
        logic [2:0] bg_mode;
        logic       m7_over;
        logic       overscan;
        logic       interlace;
    } ppu_disp_t;

    localparam ppu_disp_t PPU_DISP_RST = '{4'hF, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0};

    typedef struct packed {
        logic       vld;
        logic       vblank;
        logic [7:0] data;
        logic [7:0] addr;
        logic       pawr_n;
    } bbus_smp_t;

    localparam bbus_smp_t BBUS_SMP_RST = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1};

    function automatic logic ppu_addr_hit(logic [7:0] a);
        return (a == PPU_ADDR_INIDISP) || (a == PPU_ADDR_BGMODE) ||
               (a == PPU_ADDR_M7SEL)   || (a == PPU_ADDR_SETINI);
    endfunction

    function automatic ppu_disp_t ppu_apply(ppu_disp_t cur, logic we,
                                            logic [7:0] a, logic [7:0] d);
        ppu_disp_t r;
        r = cur;
        if (we) begin
            case (a)
                PPU_ADDR_INIDISP: begin
                    r.brightness  = d[3:0];
                    r.force_blank = d[7];
                end
                PPU_ADDR_BGMODE: r.bg_mode = d[2:0];
                PPU_ADDR_M7SEL:  r.m7_over = d[7] & ~d[6];
                PPU_ADDR_SETINI: begin
                    r.overscan  = d[2];
                    r.interlace = d[0];
                end
                default: ;
            endcase
        end
        return r;
    endfunction

endpackage

// File: rtl/snes_ppu_reg_snoop_if.sv
// SNES B-bus write-side signals plus PPU vblank, as seen by the snooper.
interface snes_ppu_reg_snoop_if;
    logic       pawr_n;
    logic [7:0] paddress;
    logic [7:0] data;
    logic       vblank;

    modport master (output pawr_n, paddress, data, vblank);
    modport slave  (input  pawr_n, paddress, data, vblank);
endinterface

// File: rtl/snes_ppu_reg_snoop_bbus_write_detect.sv
// B-bus synchroniser, PAWR_N low-width filter and rising-edge write detect.
// Events are registered; vblank rising edges come out on the same timing.
module bbus_write_detect
    import snes_ppu_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int MIN_LOW_CYC = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    snes_ppu_reg_snoop_if.slave  bus,
    output logic                 wr_evt_o,
    output logic [7:0]           wr_addr_o,
    output logic [7:0]           wr_data_o,
    output logic                 vbl_rise_o
);

    localparam int LAST = SYNC_STAGES - 1;
    localparam int PREV = SYNC_STAGES - 2;
    localparam logic [4:0] MIN_C = 5'(MIN_LOW_CYC);

    bbus_smp_t  sync_q [SYNC_STAGES];
    logic [3:0] lowcnt_q, lowcnt_d;
    logic       armed_q, armed_d;
    logic       evt_d, evt_q;
    logic       vbl_d, vbl_q;
    logic [7:0] addr_q, data_q;

    // armed blocks a write that was already low across reset release
    always_comb begin
        lowcnt_d = 4'd0;
        armed_d  = armed_q;
        if (!sync_q[LAST].pawr_n)
            lowcnt_d = (lowcnt_q == 4'hF) ? 4'hF : lowcnt_q + 4'd1;
        if (sync_q[PREV].vld && sync_q[PREV].pawr_n)
            armed_d = 1'b1;
        evt_d = !sync_q[LAST].pawr_n && sync_q[PREV].pawr_n && armed_q &&
                (({1'b0, lowcnt_q} + 5'd1) >= MIN_C);
        vbl_d = sync_q[PREV].vblank && !sync_q[LAST].vblank;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < SYNC_STAGES; i++)
                sync_q[i] <= BBUS_SMP_RST;
            lowcnt_q <= 4'd0;
            armed_q  <= 1'b0;
            evt_q    <= 1'b0;
            vbl_q    <= 1'b0;
            addr_q   <= 8'h00;
            data_q   <= 8'h00;
        end else begin
            sync_q[0] <= '{1'b1, bus.vblank, bus.data, bus.paddress, bus.pawr_n};
            for (int i = 1; i < SYNC_STAGES; i++)
                sync_q[i] <= sync_q[i-1];
            lowcnt_q <= lowcnt_d;
            armed_q  <= armed_d;
            evt_q    <= evt_d;
            vbl_q    <= vbl_d;
            addr_q   <= sync_q[LAST].addr;
            data_q   <= sync_q[LAST].data;
        end
    end

    assign wr_evt_o   = evt_q;
    assign wr_addr_o  = addr_q;
    assign wr_data_o  = data_q;
    assign vbl_rise_o = vbl_q;

endmodule

// File: rtl/snes_ppu_reg_snoop.sv
// PPU display-register snooper top. Define PPU_SNOOP_VBL_LATCH_EN to stage
// writes in shadow registers that go live on the vblank rising edge.
module snes_ppu_reg_snoop
    import snes_ppu_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter int         MIN_LOW_CYC = 2,
    parameter logic [3:0] BRIGHT_RST  = 4'hF
) (
    input  logic                 CLK_i,
    input  logic                 RST_i,
    snes_ppu_reg_snoop_if.slave  bus_if,
    output logic [3:0]           BRIGHTNESS_o,
    output logic                 FORCE_BLANK_o,
    output logic [2:0]           BG_MODE_o,
    output logic                 OVER_o,
    output logic                 OVERSCAN_o,
    output logic                 INTERLACE_o,
    output logic                 WR_STB_o,
    output logic [15:0]          FRAME_CNT_o
);

    logic       wr_evt;
    logic [7:0] wr_addr, wr_data;
    logic       vbl_rise;

    bbus_write_detect #(
        .SYNC_STAGES (SYNC_STAGES),
        .MIN_LOW_CYC (MIN_LOW_CYC)
    ) u_detect (
        .clk_i      (CLK_i),
        .rst_i      (RST_i),
        .bus        (bus_if),
        .wr_evt_o   (wr_evt),
        .wr_addr_o  (wr_addr),
        .wr_data_o  (wr_data),
        .vbl_rise_o (vbl_rise)
    );

    ppu_disp_t   disp_rst;
    ppu_disp_t   live_q, live_d;
    logic        over_q, over_d;
    logic        stb_q, stb_d;
    logic [15:0] frame_q;

    always_comb begin
        disp_rst            = PPU_DISP_RST;
        disp_rst.brightness = BRIGHT_RST;
    end

`ifdef PPU_SNOOP_VBL_LATCH_EN
    ppu_disp_t shadow_q, shadow_d;

    // commit takes shadow_d so a same-cycle write bypasses straight to live
    always_comb begin
        shadow_d = ppu_apply(shadow_q, wr_evt, wr_addr, wr_data);
        live_d   = vbl_rise ? shadow_d : live_q;
    end

    always_ff @(posedge CLK_i) begin
        if (RST_i) shadow_q <= disp_rst;
        else       shadow_q <= shadow_d;
    end
`else
    always_comb begin
        live_d = ppu_apply(live_q, wr_evt, wr_addr, wr_data);
    end
`endif

    always_comb begin
        over_d = (live_d.bg_mode == 3'd7) && live_d.m7_over;
        stb_d  = wr_evt && ppu_addr_hit(wr_addr);
    end

    always_ff @(posedge CLK_i) begin
        if (RST_i) begin
            live_q  <= disp_rst;
            over_q  <= 1'b0;
            stb_q   <= 1'b0;
            frame_q <= 16'h0000;
        end else begin
            live_q <= live_d;
            over_q <= over_d;
            stb_q  <= stb_d;
            if (vbl_rise)
                frame_q <= frame_q + 16'd1;
        end
    end

    assign BRIGHTNESS_o  = live_q.brightness;
    assign FORCE_BLANK_o = live_q.force_blank;
    assign BG_MODE_o     = live_q.bg_mode;
    assign OVER_o        = over_q;
    assign OVERSCAN_o    = live_q.overscan;
    assign INTERLACE_o   = live_q.interlace;
    assign WR_STB_o      = stb_q;
    assign FRAME_CNT_o   = frame_q;

endmodule
